// File: rtl/spi_pkg.sv
// Shared constants for the SPI master: FSM state encoding and default frame/clock settings.
package spi_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_CLK_DIV    = 4;

    // Half-period counter width; covers divider values up to 255.
    localparam int DIV_CNT_WIDTH = 8;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_XFER  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter for the SPI master. It owns the sclk level and emits
// tick (half-period boundary) plus rise/fall strobes on sclk transitions.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic toggle_en,
    output logic sclk,
    output logic tick,
    output logic rise,
    output logic fall
);

    localparam logic [DIV_CNT_WIDTH-1:0] RELOAD  = DIV_CNT_WIDTH'(CLK_DIV - 1);
    localparam logic [DIV_CNT_WIDTH-1:0] CNT_ONE = DIV_CNT_WIDTH'(1);

    logic [DIV_CNT_WIDTH-1:0] cnt_reg;
    logic                     sclk_reg;

    assign tick = en && (cnt_reg == '0);
    // A low phase only ends in a rising edge while the controller still wants pulses.
    assign rise = tick && toggle_en && !sclk_reg;
    assign fall = tick && sclk_reg;
    assign sclk = sclk_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            sclk_reg <= 1'b0;
        end else begin
            if (!en || tick) begin
                cnt_reg <= RELOAD;
            end else begin
                cnt_reg <= cnt_reg - CNT_ONE;
            end

            if (!en) begin
                sclk_reg <= 1'b0;
            end else if (rise) begin
                sclk_reg <= 1'b1;
            end else if (fall) begin
                sclk_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master, one frame per accepted start. Define SPI_MASTER_LSB_FIRST_EN
// for LSB-first framing on mosi/miso; default is MSB first. DATA_WIDTH must be >= 2.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CLK_DIV    = DEFAULT_CLK_DIV
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  cs,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int BIT_CNT_WIDTH = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_WIDTH-1:0] ALL_BITS = BIT_CNT_WIDTH'(DATA_WIDTH);
    localparam logic [BIT_CNT_WIDTH-1:0] BIT_ONE  = BIT_CNT_WIDTH'(1);

    state_t                   state_reg, state_next;
    logic [DATA_WIDTH-1:0]    tx_shift_reg, rx_shift_reg, rx_data_reg;
    logic [DATA_WIDTH-1:0]    tx_shifted, rx_shifted;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt_reg;
    logic                     tx_bit;
    logic                     div_en, toggle_en, tick, rise, fall;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign tx_bit     = tx_shift_reg[0];
    assign tx_shifted = {1'b0, tx_shift_reg[DATA_WIDTH-1:1]};
    assign rx_shifted = {miso, rx_shift_reg[DATA_WIDTH-1:1]};
`else
    assign tx_bit     = tx_shift_reg[DATA_WIDTH-1];
    assign tx_shifted = {tx_shift_reg[DATA_WIDTH-2:0], 1'b0};
    assign rx_shifted = {rx_shift_reg[DATA_WIDTH-2:0], miso};
`endif

    assign div_en    = (state_reg != ST_IDLE);
    // Once every bit has fallen, the final low half-period closes XFER without a new rise.
    assign toggle_en = (state_reg == ST_SETUP) ||
                       ((state_reg == ST_XFER) && (bit_cnt_reg != ALL_BITS));

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .rst       (rst),
        .en        (div_en),
        .toggle_en (toggle_en),
        .sclk      (sclk),
        .tick      (tick),
        .rise      (rise),
        .fall      (fall)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_SETUP;
            ST_SETUP: if (tick) state_next = ST_XFER;
            ST_XFER:  if (tick && !sclk && (bit_cnt_reg == ALL_BITS)) state_next = ST_HOLD;
            ST_HOLD:  if (tick) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            bit_cnt_reg  <= '0;
        end else begin
            state_reg <= state_next;

            if ((state_reg == ST_IDLE) && start) begin
                tx_shift_reg <= tx_data;
                rx_shift_reg <= '0;
                bit_cnt_reg  <= '0;
            end

            if (rise) begin
                rx_shift_reg <= rx_shifted;
            end

            if (fall) begin
                bit_cnt_reg <= bit_cnt_reg + BIT_ONE;
                if (bit_cnt_reg != LAST_BIT) begin
                    tx_shift_reg <= tx_shifted;
                end
            end

            if ((state_reg == ST_HOLD) && tick) begin
                rx_data_reg <= rx_shift_reg;
            end
        end
    end

    assign busy    = (state_reg != ST_IDLE);
    assign done    = (state_reg == ST_DONE);
    assign cs      = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign mosi    = (state_reg == ST_IDLE) ? 1'b0 : tx_bit;
    assign rx_data = rx_data_reg;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl (DATA_WIDTH=8, CLK_DIV=2) with an rx_data scoreboard.
module tb_spi_master_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] tx_data;
    logic       busy, done, cs, sclk, mosi;
    logic [7:0] rx_data;
    logic       miso;
    logic       loop_en;
    logic       miso_fixed;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    assign miso = loop_en ? mosi : miso_fixed;

    spi_master_ctrl #(
        .DATA_WIDTH (8),
        .CLK_DIV    (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .tx_data (tx_data),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .cs      (cs),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Order in which bits of v appear on the wire, packed first-bit-in-MSB.
    function automatic logic [7:0] wire_order(input logic [7:0] v);
        logic [7:0] r;
`ifdef SPI_MASTER_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[7-i] = v[i];
`else
        r = v;
`endif
        return r;
    endfunction

    // Scoreboard: every done pulse pops one expected frame.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            checks++;
            txn++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected_done rx_data=%02h required=no done", rx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("TXN %0d rx_data=%02h expected=%02h", txn, rx_data, mon_exp);
                if (rx_data !== mon_exp) begin
                    errors++;
                    $display("FAIL scoreboard_rx_data got=%02h required=%02h", rx_data, mon_exp);
                end
            end
        end
    end

    // Runs one frame; must be called at a negedge with the DUT idle. Cycle 0 is acceptance.
    task automatic run_frame(input logic [7:0] tx, input int pulse1, input int pulse2,
                             output logic c1_cs, output logic c1_busy, output logic c1_mosi,
                             output int done_cyc, output int rises, output logic [7:0] bits,
                             output int cs_low, output int dones);
        logic prev_sclk;
        tx_data = tx;
        start   = 1'b1;
        done_cyc = -1; rises = 0; bits = 8'h00; cs_low = 0; dones = 0;
        c1_cs = 1'bx; c1_busy = 1'bx; c1_mosi = 1'bx;
        prev_sclk = 1'b0;
        @(posedge clk);
        #1;
        start   = 1'b0;
        tx_data = ~tx;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (c == 1) begin
                c1_cs = cs; c1_busy = busy; c1_mosi = mosi;
            end
            if (sclk && !prev_sclk) begin
                if (rises < 8) bits[7-rises] = mosi;
                rises++;
            end
            prev_sclk = sclk;
            if (!cs) cs_low++;
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = c;
            end
            start = (c == pulse1 || c == pulse2);
            if (done_cyc > 0 && c >= done_cyc + 3) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (cs !== 1'b1)      begin errors++; $display("FAIL reset_cs got=%b required=1", cs); end
        checks++; if (sclk !== 1'b0)    begin errors++; $display("FAIL reset_sclk got=%b required=0", sclk); end
        checks++; if (mosi !== 1'b0)    begin errors++; $display("FAIL reset_mosi got=%b required=0", mosi); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b required=0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got=%b required=0", done); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%02h required=00", rx_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_loopback(input logic [7:0] tx);
        logic c1_cs, c1_busy, c1_mosi;
        int done_cyc, rises, cs_low, dones;
        logic [7:0] bits, exp_bits;
        exp_bits = wire_order(tx);
        loop_en = 1'b1;
        exp_q.push_back(tx);
        run_frame(tx, -1, -1, c1_cs, c1_busy, c1_mosi, done_cyc, rises, bits, cs_low, dones);
        checks++; if (c1_cs !== 1'b0)   begin errors++; $display("FAIL loop_c1_cs tx=%02h got=%b required=0", tx, c1_cs); end
        checks++; if (c1_busy !== 1'b1) begin errors++; $display("FAIL loop_c1_busy tx=%02h got=%b required=1", tx, c1_busy); end
        checks++; if (c1_mosi !== exp_bits[7]) begin errors++; $display("FAIL loop_first_mosi tx=%02h got=%b required=%b", tx, c1_mosi, exp_bits[7]); end
        checks++; if (rises != 8)       begin errors++; $display("FAIL loop_sclk_pulses tx=%02h got=%0d required=8", tx, rises); end
        checks++; if (bits !== exp_bits) begin errors++; $display("FAIL loop_mosi_bits tx=%02h got=%02h required=%02h", tx, bits, exp_bits); end
        checks++; if (done_cyc != 37)   begin errors++; $display("FAIL loop_done_cycle tx=%02h got=%0d required=37", tx, done_cyc); end
        checks++; if (cs_low != 36)     begin errors++; $display("FAIL loop_cs_low tx=%02h got=%0d required=36", tx, cs_low); end
        checks++; if (dones != 1)       begin errors++; $display("FAIL loop_done_count tx=%02h got=%0d required=1", tx, dones); end
    endtask

    task automatic test_miso_ones;
        logic c1_cs, c1_busy, c1_mosi;
        int done_cyc, rises, cs_low, dones;
        logic [7:0] bits;
        loop_en = 1'b0;
        miso_fixed = 1'b1;
        exp_q.push_back(8'hFF);
        run_frame(8'h00, -1, -1, c1_cs, c1_busy, c1_mosi, done_cyc, rises, bits, cs_low, dones);
        checks++; if (cs_low != 36)    begin errors++; $display("FAIL ones_cs_low got=%0d required=36", cs_low); end
        checks++; if (done_cyc != 37)  begin errors++; $display("FAIL ones_done_cycle got=%0d required=37", done_cyc); end
        checks++; if (bits !== 8'h00)  begin errors++; $display("FAIL ones_mosi_bits got=%02h required=00", bits); end
        loop_en = 1'b1;
    endtask

    task automatic test_start_ignored;
        logic c1_cs, c1_busy, c1_mosi;
        int done_cyc, rises, cs_low, dones;
        logic [7:0] bits;
        loop_en = 1'b1;
        exp_q.push_back(8'hC3);
        run_frame(8'hC3, 5, 36, c1_cs, c1_busy, c1_mosi, done_cyc, rises, bits, cs_low, dones);
        checks++; if (dones != 1)     begin errors++; $display("FAIL ignore_done_count got=%0d required=1", dones); end
        checks++; if (cs_low != 36)   begin errors++; $display("FAIL ignore_cs_low got=%0d required=36", cs_low); end
        checks++; if (done_cyc != 37) begin errors++; $display("FAIL ignore_done_cycle got=%0d required=37", done_cyc); end
        checks++; if (rises != 8)     begin errors++; $display("FAIL ignore_sclk_pulses got=%0d required=8", rises); end
    endtask

    task automatic test_reset_midframe;
        logic c1_cs, c1_busy, c1_mosi;
        int done_cyc, rises, cs_low, dones, dn;
        logic [7:0] bits;
        loop_en = 1'b1;
        tx_data = 8'h5A;
        start   = 1'b1;
        exp_q.push_back(8'h5A);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        #1;
        checks++; if (cs !== 1'b1)       begin errors++; $display("FAIL abort_cs got=%b required=1", cs); end
        checks++; if (sclk !== 1'b0)     begin errors++; $display("FAIL abort_sclk got=%b required=0", sclk); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL abort_busy got=%b required=0", busy); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL abort_rx_data got=%02h required=00", rx_data); end
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dn++;
        end
        checks++; if (dn != 0) begin errors++; $display("FAIL abort_no_done got=%0d required=0", dn); end
        rst = 1'b0;
        exp_q.push_back(8'h3C);
        run_frame(8'h3C, -1, -1, c1_cs, c1_busy, c1_mosi, done_cyc, rises, bits, cs_low, dones);
        checks++; if (c1_busy !== 1'b1) begin errors++; $display("FAIL post_reset_accept got=%b required=1", c1_busy); end
        checks++; if (done_cyc != 37)   begin errors++; $display("FAIL post_reset_done_cycle got=%0d required=37", done_cyc); end
        checks++; if (bits !== wire_order(8'h3C)) begin errors++; $display("FAIL post_reset_mosi_bits got=%02h required=%02h", bits, wire_order(8'h3C)); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] vals [3];
        int dones, hi_run, min_gap, gaps, after;
        bit seen_low;
        vals[0] = 8'h01; vals[1] = 8'h80; vals[2] = 8'hFF;
        loop_en = 1'b1;
        dones = 0; hi_run = 0; min_gap = 1000; gaps = 0; after = 0; seen_low = 0;
        tx_data = vals[0];
        start   = 1'b1;
        exp_q.push_back(vals[0]);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (cs) begin
                hi_run++;
            end else begin
                if (seen_low && hi_run > 0) begin
                    gaps++;
                    if (hi_run < min_gap) min_gap = hi_run;
                end
                hi_run = 0;
                seen_low = 1;
            end
            if (done) begin
                dones++;
                if (dones < 3) begin
                    tx_data = vals[dones];
                    exp_q.push_back(vals[dones]);
                end else begin
                    start = 1'b0;
                end
            end
            if (dones >= 3) begin
                after++;
                if (after > 3) break;
            end
        end
        start = 1'b0;
        checks++; if (dones != 3)   begin errors++; $display("FAIL b2b_done_count got=%0d required=3", dones); end
        checks++; if (gaps != 2)    begin errors++; $display("FAIL b2b_gap_count got=%0d required=2", gaps); end
        checks++; if (min_gap < 2)  begin errors++; $display("FAIL b2b_cs_gap got=%0d required>=2", min_gap); end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        tx_data    = 8'h00;
        loop_en    = 1'b1;
        miso_fixed = 1'b0;
        test_reset();
        test_loopback(8'hA5);
        test_loopback(8'h01);
        test_miso_ones();
        test_start_ignored();
        test_reset_midframe();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving bits per frame.
REQ-002 The module SHALL have parameter CLK_DIV, default 4, giving the sclk half-period in clk cycles (legal range 1 to 255).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a frame; sampled only in IDLE.
REQ-006 tx_data  input  DATA_WIDTH  frame to transmit; latched when start is accepted.
REQ-007 busy  output  1  high from the cycle after acceptance until the DONE cycle, inclusive.
REQ-008 done  output  1  single-cycle pulse when rx_data is valid.
REQ-009 rx_data  output  DATA_WIDTH  last received frame; held until the next done.
REQ-010 cs  output  1  active-low slave select.
REQ-011 sclk  output  1  SPI clock, mode 0 (idle low).
REQ-012 mosi  output  1  serial data out.
REQ-013 miso  input  1  serial data in.

Function
REQ-014 The FSM SHALL have states IDLE, SETUP, XFER, HOLD and DONE.
REQ-015 IDLE with start=1 SHALL latch tx_data into the shift register and move to SETUP; the next cycle SHALL have cs=0, busy=1 and mosi=first bit.
REQ-016 SETUP SHALL last CLK_DIV cycles with sclk=0, then move to XFER.
REQ-017 XFER SHALL generate DATA_WIDTH sclk periods, each CLK_DIV cycles high followed by CLK_DIV cycles low.
REQ-018 On each sclk rising transition, miso SHALL be shifted into the receive register.
REQ-019 On each sclk falling transition except the last, mosi SHALL advance to the next bit.
REQ-020 After the last falling transition, the FSM SHALL move to HOLD for CLK_DIV cycles with cs=0 and sclk=0.
REQ-021 The cycle after HOLD, the FSM SHALL move to DONE: cs=1, rx_data updated, done=1 for exactly one cycle, then return to IDLE.
REQ-022 With acceptance at cycle 0, done SHALL be high in cycle (2*DATA_WIDTH+2)*CLK_DIV+1.
REQ-023 Default bit order SHALL be MSB first on both mosi and miso.
REQ-024 start SHALL be ignored while busy=1 and in the DONE cycle; a continuously high start SHALL produce back-to-back frames with cs=1 for at least 2 cycles between them.
REQ-025 tx_data changes after acceptance SHALL NOT affect the frame in progress.
REQ-026 The half-period counter SHALL be wide enough for 255 and SHALL reload to CLK_DIV-1 on every sclk transition, with no wrap-around beyond terminal count.
REQ-027 In IDLE, mosi SHALL be 0.

Reset
REQ-028 rst=1 SHALL asynchronously force IDLE with cs=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, counters=0 and shift registers=0.
REQ-029 Reset mid-frame SHALL abort the frame immediately, produce no done pulse, and leave rx_data=0.
REQ-030 The first start SHALL be accepted on the first rising clk edge after rst deasserts.

Configuration
REQ-031 With macro SPI_MASTER_LSB_FIRST_EN defined, both mosi and miso SHALL be LSB first and rx_data SHALL be assembled accordingly.
REQ-032 Without SPI_MASTER_LSB_FIRST_EN defined, the frame SHALL be MSB first.
REQ-033 Latency and timing SHALL be identical in both builds.

Structure
REQ-034 Shared package spi_pkg SHALL hold the FSM state encoding, the default DATA_WIDTH and the default CLK_DIV constants.
REQ-035 Sub-module spi_clk_div SHALL provide the half-period counter and emit rise/fall strobes; it SHALL be reset by rst and enabled only outside IDLE.

Verification
REQ-036 DATA_WIDTH=8, CLK_DIV=2, tx_data=0xA5, miso looped from mosi -> 8 sclk pulses, mosi bits 1,0,1,0,0,1,0,1, done in cycle 37, rx_data=0xA5.
REQ-037 miso tied to 1, tx_data=0x00 -> rx_data=0xFF; cs low for exactly 36 cycles.
REQ-038 Pulse start again at cycles 5 and 36 of an active frame -> both ignored; exactly one done pulse.
REQ-039 Assert rst at cycle 10 of a frame -> same cycle cs=1, sclk=0, busy=0; no done; a new start with tx_data=0x3C then completes normally.
REQ-040 start held high for 3 frames, tx_data=0x01,0x80,0xFF -> three done pulses, cs high at least 2 cycles between frames, rx_data matches each value in loopback.
REQ-041 SPI_MASTER_LSB_FIRST_EN build, tx_data=0x01 -> first mosi bit 1, rest 0; loopback rx_data=0x01.
